// File: rtl/operand2_decode.sv
// ---------------------------------------------------------------------------
// operand2_decode
//
// Purpose:
//   Decodes operand 2 of an ARM data-processing instruction and feeds the
//   barrel shifter.  Three operand forms are handled:
//     - 8-bit immediate rotated right by 2*rot4 (Inst[25]=1)
//     - register Rm shifted by a 5-bit immediate amount (Inst[25]=0, Inst[4]=0)
//     - register Rm shifted by the low byte of register Rs (Inst[25]=0, Inst[4]=1)
//   Immediates are presented one edge after accept.  Register forms issue a
//   register-file read on the accepting cycle and present the operands one
//   cycle later, when the register-file data is valid.
//
// Ports:
//   clk, rst_n     clock (rising edge), synchronous active-low reset
//   Flush          synchronous pipeline kill, drops any held or pending operand
//   In_Valid       instruction offered upstream
//   In_Ready       instruction accepted when In_Valid && In_Ready at the edge
//   Inst, Inst_PC  instruction word and its address
//   Rm_Addr        register-file port A address (Inst[3:0]), combinational
//   Rs_Addr        register-file port B address (Inst[11:8]), combinational
//   Rf_Rd_En       register-file read strobe, accepting cycle of a register form
//   Rm_Data        port A read data, valid the cycle after Rf_Rd_En
//   Rs_Data        port B read data, valid the cycle after Rf_Rd_En
//   Out_Valid      operands valid towards the shifter
//   Out_Ready      shifter consumes the operands
//   Shift_Data     value to shift
//   Shift_Num      shift amount
//   SHIFT_OP       {type[1:0], amount_from_register}; type 00 LSL, 01 LSR,
//                  10 ASR, 11 ROR
// ---------------------------------------------------------------------------
module operand2_decode #(
    parameter int unsigned PC_OFS_IMM = 8,
    parameter int unsigned PC_OFS_REG = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Flush,

    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic [31:0] Inst,
    input  logic [31:0] Inst_PC,

    output logic [3:0]  Rm_Addr,
    output logic [3:0]  Rs_Addr,
    output logic        Rf_Rd_En,
    input  logic [31:0] Rm_Data,
    input  logic [31:0] Rs_Data,

    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [31:0] Shift_Data,
    output logic [7:0]  Shift_Num,
    output logic [2:0]  SHIFT_OP
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_OUT   = 2'd2
    } state_e;

    localparam logic [31:0] PC_OFS_IMM_W = 32'(PC_OFS_IMM);
    localparam logic [31:0] PC_OFS_REG_W = 32'(PC_OFS_REG);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Rotated immediate is sent as a register-amount ROR so that rotate 0
    // is a plain pass-through (not RRX) and the shifter carry-out equals C.
    function automatic logic [7:0] imm_rot_amount(input logic [3:0] rot4);
        return {3'b000, rot4, 1'b0};
    endfunction

    // r15 reads as the instruction address plus the pipeline offset; the
    // offset is larger when the shift amount itself comes from a register.
    // The sum is 32-bit modulo.
    function automatic logic [31:0] rm_value(input logic        rm_is_pc,
                                             input logic        amt_from_reg,
                                             input logic [31:0] pc,
                                             input logic [31:0] rf_data);
        logic [31:0] ofs;
        ofs = amt_from_reg ? PC_OFS_REG_W : PC_OFS_IMM_W;
        return rm_is_pc ? (pc + ofs) : rf_data;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e      state_q,      state_d;
    logic [31:0] shift_data_q, shift_data_d;
    logic [7:0]  shift_num_q,  shift_num_d;
    logic [2:0]  shift_op_q,   shift_op_d;

    // Fields captured at accept of a register form, consumed in FETCH.
    logic [1:0]  lat_type_q,   lat_type_d;
    logic        lat_reg_q,    lat_reg_d;
    logic [4:0]  lat_imm5_q,   lat_imm5_d;
    logic        lat_pc15_q,   lat_pc15_d;
    logic [31:0] lat_pc_q,     lat_pc_d;

    logic        in_ready_c;
    logic        accept_c;

    // Bits of the instruction and Rs data the decoder has no use for.
    logic        unused_bits;
    assign unused_bits = ^{Inst[31:26], Inst[24:12], Rs_Data[31:8]};

    // ------------------------------------------------------------------
    // Handshake and register-file read port
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_c = rst_n && !Flush &&
                     ((state_q == S_IDLE) || ((state_q == S_OUT) && Out_Ready));
        accept_c   = In_Valid && in_ready_c;
    end

    assign In_Ready = in_ready_c;
    assign Rm_Addr  = Inst[3:0];
    assign Rs_Addr  = Inst[11:8];
    assign Rf_Rd_En = accept_c && !Inst[25];

    // ------------------------------------------------------------------
    // Next-state and output-register logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        shift_data_d = shift_data_q;
        shift_num_d  = shift_num_q;
        shift_op_d   = shift_op_q;
        lat_type_d   = lat_type_q;
        lat_reg_d    = lat_reg_q;
        lat_imm5_d   = lat_imm5_q;
        lat_pc15_d   = lat_pc15_q;
        lat_pc_d     = lat_pc_q;

        if (Flush) begin
            // Data registers keep their last values; only validity is killed.
            state_d = S_IDLE;
        end else if (accept_c) begin
            // accept_c already implies IDLE, or OUT being consumed.
            if (Inst[25]) begin
                state_d      = S_OUT;
                shift_data_d = {24'b0, Inst[7:0]};
                shift_num_d  = imm_rot_amount(Inst[11:8]);
                shift_op_d   = 3'b111;
            end else begin
                state_d    = S_FETCH;
                lat_type_d = Inst[6:5];
                lat_reg_d  = Inst[4];
                lat_imm5_d = Inst[11:7];
                lat_pc15_d = (Inst[3:0] == 4'hF);
                lat_pc_d   = Inst_PC;
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    state_d      = S_OUT;
                    shift_data_d = rm_value(lat_pc15_q, lat_reg_q, lat_pc_q, Rm_Data);
                    // imm5 = 0 is passed as is; the shifter gives it its
                    // LSR/ASR #32 and RRX meanings.
                    shift_num_d  = lat_reg_q ? Rs_Data[7:0] : {3'b000, lat_imm5_q};
                    shift_op_d   = {lat_type_q, lat_reg_q};
                end
                S_OUT: begin
                    if (Out_Ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            shift_data_q <= 32'h0;
            shift_num_q  <= 8'h0;
            shift_op_q   <= 3'b000;
            lat_type_q   <= 2'b00;
            lat_reg_q    <= 1'b0;
            lat_imm5_q   <= 5'h0;
            lat_pc15_q   <= 1'b0;
            lat_pc_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            shift_data_q <= shift_data_d;
            shift_num_q  <= shift_num_d;
            shift_op_q   <= shift_op_d;
            lat_type_q   <= lat_type_d;
            lat_reg_q    <= lat_reg_d;
            lat_imm5_q   <= lat_imm5_d;
            lat_pc15_q   <= lat_pc15_d;
            lat_pc_q     <= lat_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    assign Out_Valid  = (state_q == S_OUT);
    assign Shift_Data = shift_data_q;
    assign Shift_Num  = shift_num_q;
    assign SHIFT_OP   = shift_op_q;

endmodule

// File: tb/tb_operand2_decode.sv
module tb_operand2_decode;

    logic        clk;
    logic        rst_n;
    logic        Flush;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] Inst;
    logic [31:0] Inst_PC;
    logic [3:0]  Rm_Addr;
    logic [3:0]  Rs_Addr;
    logic        Rf_Rd_En;
    logic [31:0] Rm_Data;
    logic [31:0] Rs_Data;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Shift_Data;
    logic [7:0]  Shift_Num;
    logic [2:0]  SHIFT_OP;

    int errors = 0;
    int checks = 0;

    operand2_decode #(
        .PC_OFS_IMM(8),
        .PC_OFS_REG(12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Flush     (Flush),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Inst      (Inst),
        .Inst_PC   (Inst_PC),
        .Rm_Addr   (Rm_Addr),
        .Rs_Addr   (Rs_Addr),
        .Rf_Rd_En  (Rf_Rd_En),
        .Rm_Data   (Rm_Data),
        .Rs_Data   (Rs_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Shift_Data(Shift_Data),
        .Shift_Num (Shift_Num),
        .SHIFT_OP  (SHIFT_OP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rm;
        logic [31:0] rs;
        logic [31:0] exp_data;
        logic [7:0]  exp_num;
        logic [2:0]  exp_op;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d,
                           input logic [7:0] n, input logic [2:0] op);
        chk({tag, " data"}, Shift_Data, d);
        chk({tag, " num"},  32'(Shift_Num), 32'(n));
        chk({tag, " op"},   32'(SHIFT_OP),  32'(op));
    endtask

    initial begin
        // inst, pc, rm_data, rs_data, exp data, exp num, exp op
        vecs[0] = '{32'hE3A004FF, 32'h0,        32'h0,        32'h0,   32'h000000FF, 8'd8,  3'b111};
        vecs[1] = '{32'hE1A00043, 32'h0,        32'h80000000, 32'h0,   32'h80000000, 8'd0,  3'b100};
        vecs[2] = '{32'hE1A00211, 32'h0,        32'hDEADBEEF, 32'h121, 32'hDEADBEEF, 8'h21, 3'b001};
        vecs[3] = '{32'hE1A0021F, 32'h1000,     32'h55555555, 32'h121, 32'h0000100C, 8'h21, 3'b001};
        vecs[4] = '{32'hE1A002AF, 32'h1000,     32'h55555555, 32'h0,   32'h00001008, 8'd5,  3'b010};
        vecs[5] = '{32'hE1A00FE7, 32'h0,        32'h12345678, 32'h0,   32'h12345678, 8'd31, 3'b110};
        vecs[6] = '{32'hE3A00FA5, 32'h0,        32'h0,        32'h0,   32'h000000A5, 8'd30, 3'b111};
        vecs[7] = '{32'hE3A00000, 32'h0,        32'h0,        32'h0,   32'h00000000, 8'd0,  3'b111};
        vecs[8] = '{32'hE1A0031F, 32'hFFFFFFF8, 32'h0,        32'hFFFFFF00, 32'h00000004, 8'd0, 3'b001};

        rst_n = 1'b0; Flush = 1'b0; In_Valid = 1'b1; Inst = 32'hE1A00043;
        Inst_PC = 32'h0; Rm_Data = 32'h0; Rs_Data = 32'h0; Out_Ready = 1'b0;

        // Reset: nothing accepted and nothing read while rst_n is low.
        step();
        chk("rst in_ready", 32'(In_Ready), 32'd0);
        chk("rst rf_rd_en", 32'(Rf_Rd_En), 32'd0);
        step();
        chk("rst out_valid", 32'(Out_Valid), 32'd0);
        chk_out("rst", 32'h0, 8'h0, 3'b000);
        In_Valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst release in_ready", 32'(In_Ready), 32'd1);

        // Table-driven single transactions.
        for (int i = 0; i < 9; i++) begin
            In_Valid = 1'b1; Inst = vecs[i].inst; Inst_PC = vecs[i].pc;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(In_Ready), 32'd1);
            chk($sformatf("v%0d rf_rd_en", i), 32'(Rf_Rd_En), 32'(!vecs[i].inst[25]));
            chk($sformatf("v%0d rm_addr", i), 32'(Rm_Addr), 32'(vecs[i].inst[3:0]));
            chk($sformatf("v%0d rs_addr", i), 32'(Rs_Addr), 32'(vecs[i].inst[11:8]));
            step();
            In_Valid = 1'b0; Inst = 32'h0; Inst_PC = 32'h0;
            if (!vecs[i].inst[25]) begin
                #1;
                chk($sformatf("v%0d fetch out_valid", i), 32'(Out_Valid), 32'd0);
                chk($sformatf("v%0d fetch in_ready", i), 32'(In_Ready), 32'd0);
                Rm_Data = vecs[i].rm; Rs_Data = vecs[i].rs;
                step();
                Rm_Data = 32'h0; Rs_Data = 32'h0;
            end
            chk($sformatf("v%0d out_valid", i), 32'(Out_Valid), 32'd1);
            chk_out($sformatf("v%0d", i), vecs[i].exp_data, vecs[i].exp_num, vecs[i].exp_op);
            Out_Ready = 1'b1;
            step();
            Out_Ready = 1'b0;
            chk($sformatf("v%0d drain out_valid", i), 32'(Out_Valid), 32'd0);
        end

        // Back-pressure, then back-to-back accepts out of OUT.
        In_Valid = 1'b1; Inst = 32'hE3A004FF;
        step();
        Inst = 32'hE3A00FA5;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d in_ready", c), 32'(In_Ready), 32'd0);
            chk($sformatf("stall%0d out_valid", c), 32'(Out_Valid), 32'd1);
            chk_out($sformatf("stall%0d", c), 32'h000000FF, 8'd8, 3'b111);
            step();
        end
        Out_Ready = 1'b1;
        #1;
        chk("b2b imm in_ready", 32'(In_Ready), 32'd1);
        step();
        chk("b2b imm out_valid", 32'(Out_Valid), 32'd1);
        chk_out("b2b imm", 32'h000000A5, 8'd30, 3'b111);
        Inst = 32'hE1A00043;
        #1;
        chk("b2b reg in_ready", 32'(In_Ready), 32'd1);
        chk("b2b reg rf_rd_en", 32'(Rf_Rd_En), 32'd1);
        step();
        In_Valid = 1'b0; Out_Ready = 1'b0; Inst = 32'h0;
        chk("b2b reg fetch out_valid", 32'(Out_Valid), 32'd0);
        Rm_Data = 32'h00000F0F;
        step();
        Rm_Data = 32'h0;
        chk("b2b reg out_valid", 32'(Out_Valid), 32'd1);
        chk_out("b2b reg", 32'h00000F0F, 8'd0, 3'b100);
        Out_Ready = 1'b1;
        step();
        Out_Ready = 1'b0;
        chk("idle out_valid", 32'(Out_Valid), 32'd0);
        chk_out("idle hold", 32'h00000F0F, 8'd0, 3'b100);

        // Flush during FETCH discards the pending operand.
        In_Valid = 1'b1; Inst = 32'hE1A00043;
        step();
        In_Valid = 1'b0; Flush = 1'b1; Rm_Data = 32'h11111111;
        #1;
        chk("flush in_ready", 32'(In_Ready), 32'd0);
        step();
        Flush = 1'b0; Rm_Data = 32'h0;
        #1;
        chk("flush out_valid", 32'(Out_Valid), 32'd0);
        chk("flush in_ready after", 32'(In_Ready), 32'd1);
        step();
        chk("flush stays idle", 32'(Out_Valid), 32'd0);

        // Flush together with an offer in IDLE: not accepted.
        Flush = 1'b1; In_Valid = 1'b1; Inst = 32'hE1A00043;
        #1;
        chk("flush+valid in_ready", 32'(In_Ready), 32'd0);
        chk("flush+valid rf_rd_en", 32'(Rf_Rd_En), 32'd0);
        step();
        Flush = 1'b0; In_Valid = 1'b0;
        chk("flush+valid out_valid", 32'(Out_Valid), 32'd0);
        step();
        chk("flush+valid no fetch", 32'(Out_Valid), 32'd0);

        // Reset while holding a stalled operand.
        In_Valid = 1'b1; Inst = 32'hE3A004FF;
        step();
        In_Valid = 1'b0;
        chk("pre-reset out_valid", 32'(Out_Valid), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("reset out_valid", 32'(Out_Valid), 32'd0);
        chk_out("reset", 32'h0, 8'h0, 3'b000);
        chk("reset in_ready", 32'(In_Ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
